// File: rtl/fp_minmax_reduce.sv
// fp_minmax_reduce: sequential min/max reduction over a stream of
// pre-extended, pre-classified FP operands, folded through a single shared
// fp_max compare/select datapath into a running accumulator.
//
// Optional build macro: FP_MINMAX_REDUCE_PIPE_EN
//   defined   -> one input register stage ahead of fp_max (fold one cycle
//                after acceptance, in_ready drops for the final drain cycle)
//   undefined -> accepted element folds on the same edge it is accepted
//
// Compare form (ext): bit 64 = sign, bits 63:0 = magnitude, ordered as an
// unsigned integer. Class: bit 8 = sNaN, bit 9 = qNaN.
module fp_minmax_reduce #(
  parameter int LEN_W = 8
) (
  input  logic             reset,
  input  logic             clock,
  input  logic             start,
  input  logic [1:0]       fmt,
  input  logic [2:0]       rm,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic [64:0]      in_ext,
  input  logic [9:0]       in_class,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [4:0]       out_flags,
  output logic             busy
);

  localparam logic [63:0] CNAN_D = 64'h7ff8_0000_0000_0000;
  localparam logic [63:0] CNAN_S = 64'h0000_0000_7fc0_0000;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_q;
  logic [1:0]       fmt_q;
  logic             max_q;
  logic [LEN_W-1:0] rem_q;
  logic             first_q;
  logic [63:0]      acc_data_q;
  logic [64:0]      acc_ext_q;
  logic [9:0]       acc_class_q;
  logic [4:0]       flags_q;
  logic             in_ready_q, out_valid_q, busy_q;

  // Element handed to the fold stage
  logic             acc_fire;
  logic             f_vld, f_last;
  logic [63:0]      f_data;
  logic [64:0]      f_ext;
  logic [9:0]       f_class;

  assign acc_fire = in_valid & in_ready_q;

`ifdef FP_MINMAX_REDUCE_PIPE_EN
  logic             p_vld_q;
  logic [63:0]      p_data_q;
  logic [64:0]      p_ext_q;
  logic [9:0]       p_class_q;

  // Input register stage: capture each accepted element for next-cycle fold
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_vld_q   <= 1'b0;
      p_data_q  <= '0;
      p_ext_q   <= '0;
      p_class_q <= '0;
    end else begin
      p_vld_q <= acc_fire;
      if (acc_fire) begin
        p_data_q  <= in_data;
        p_ext_q   <= in_ext;
        p_class_q <= in_class;
      end
    end
  end

  assign f_vld   = p_vld_q;
  assign f_data  = p_data_q;
  assign f_ext   = p_ext_q;
  assign f_class = p_class_q;
  // in_ready is low once rem hits 0, so any fold seen with rem == 0 is the last
  assign f_last  = (rem_q == '0);
`else
  assign f_vld   = acc_fire;
  assign f_data  = in_data;
  assign f_ext   = in_ext;
  assign f_class = in_class;
  assign f_last  = (rem_q == LEN_W'(1));
`endif

  // fp_max datapath (operand 1 = accumulator, operand 2 = element)
  logic [63:0] cnan;
  logic        a_nan, b_nan, a_lt_b, sel_b;
  logic [63:0] fm_res;
  logic [4:0]  fm_flags;
  logic [64:0] nxt_ext_d;
  logic [9:0]  nxt_class_d;

  // Compare/select plus accumulator ext/class follow-up
  always_comb begin
    cnan     = (fmt_q == 2'd1) ? CNAN_D : CNAN_S;
    a_nan    = acc_class_q[8] | acc_class_q[9];
    b_nan    = f_class[8] | f_class[9];
    fm_flags = {acc_class_q[8] | f_class[8], 4'b0000};
    // Sign-magnitude order; -0 < +0 falls out of the sign test
    if (acc_ext_q[64] != f_ext[64])
      a_lt_b = acc_ext_q[64];
    else if (!acc_ext_q[64])
      a_lt_b = acc_ext_q[63:0] < f_ext[63:0];
    else
      a_lt_b = acc_ext_q[63:0] > f_ext[63:0];
    // max picks the larger, min the smaller
    sel_b = max_q ? a_lt_b : !a_lt_b;
    if (a_nan && b_nan)  fm_res = cnan;
    else if (a_nan)      fm_res = f_data;
    else if (b_nan)      fm_res = acc_data_q;
    else                 fm_res = sel_b ? f_data : acc_data_q;

    nxt_ext_d   = acc_ext_q;
    nxt_class_d = acc_class_q;
    if (a_nan && b_nan) begin
      nxt_ext_d   = {1'b0, cnan};
      nxt_class_d = 10'h200;
    end else if (fm_res == f_data) begin
      nxt_ext_d   = f_ext;
      nxt_class_d = f_class;
    end
  end

  // Control FSM and accumulator with registered handshake outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fmt_q       <= '0;
      max_q       <= 1'b0;
      rem_q       <= '0;
      first_q     <= 1'b0;
      acc_data_q  <= '0;
      acc_ext_q   <= '0;
      acc_class_q <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            fmt_q   <= fmt;
            max_q   <= rm[0];
            rem_q   <= len;
            first_q <= 1'b0;
            flags_q <= '0;
            busy_q  <= 1'b1;
            if (len == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              acc_data_q  <= (fmt == 2'd1) ? CNAN_D : CNAN_S;
            end else begin
              state_q    <= ACCUM;
              in_ready_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (acc_fire) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) in_ready_q <= 1'b0;
          end
          if (f_vld) begin
            first_q <= 1'b1;
            if (!first_q) begin
              // First element seeds the accumulator as-is, no compare
              acc_data_q  <= f_data;
              acc_ext_q   <= f_ext;
              acc_class_q <= f_class;
            end else begin
              acc_data_q  <= fm_res;
              acc_ext_q   <= nxt_ext_d;
              acc_class_q <= nxt_class_d;
              flags_q     <= flags_q | fm_flags;
            end
            if (f_last) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign out_result = acc_data_q;
  assign out_flags  = flags_q;

  // Bits carried for completeness but never consulted here
  logic unused_bits;
  assign unused_bits = ^{rm[2:1], acc_class_q[7:0]};

endmodule
